// File: rtl/execute_muldiv_pkg.sv
// Shared definitions for the execute-stage iterative multiply/divide unit.
package execute_muldiv_pkg;

    // Operation encodings as issued by decode; 3'b010 and 3'b011 are reserved.
    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_REM   = 3'b110;
    localparam logic [2:0] OP_REMU  = 3'b111;

    // Sequencer states.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    // Quotient returned on divide by zero; sliced down to the datapath width.
    localparam logic [63:0] DIV0_ALL_ONES = '1;

    // DIV and REM are signed; DIVU and REMU are not.
    function automatic logic op_is_signed_div(input logic [2:0] op);
        return op[2] & ~op[0];
    endfunction

endpackage

// File: rtl/execute_muldiv_if.sv
// Decode/writeback-facing signal bundle of the multiply/divide unit.
interface execute_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_start;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [4:0]       in_regdest;
    logic             in_writereg;
    logic             in_stall;
    logic             in_flush;
    logic             out_stall;
    logic [4:0]       out_regdest;
    logic             out_writereg;
    logic [WIDTH-1:0] out_wbvalue;

    // Pipeline side: issues ops and consumes the writeback.
    modport master (
        output in_start, in_op, in_a, in_b, in_regdest, in_writereg, in_stall, in_flush,
        input  out_stall, out_regdest, out_writereg, out_wbvalue
    );

    // Unit side.
    modport slave (
        input  in_start, in_op, in_a, in_b, in_regdest, in_writereg, in_stall, in_flush,
        output out_stall, out_regdest, out_writereg, out_wbvalue
    );
endinterface

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step.
// o_result reflects the state after the current step, so the sequencer can
// register it on the final iteration edge.
module muldiv_core
    import execute_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);
    // Multiply: upper half accumulates, lower half holds the remaining multiplier.
    // Divide: lower half holds the dividend shifting out and the quotient shifting in.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_mcand;    // multiplicand or |divisor|
    logic [2:0]         r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;

    logic               w_signed;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rs;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed = op_is_signed_div(i_op);
    assign w_a_abs  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_abs  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                  + ({(WIDTH+1){r_acc[0]}} & {1'b0, r_mcand});
    // Partial remainder is WIDTH+1 bits wide so the trial subtract never loses a bit.
    assign w_rs   = {r_rem, r_acc[WIDTH-1]};
    assign w_diff = w_rs - {1'b0, r_mcand};
    assign w_ge   = ~w_diff[WIDTH];

    // One iteration of whichever algorithm the latched op selects.
    always_comb begin
        w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        w_rem_nxt = r_rem;
        if (r_op[2]) begin
            w_acc_nxt = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
            w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rs[WIDTH-1:0];
        end
    end

    assign w_quo_fix = r_div0  ? DIV0_ALL_ONES[WIDTH-1:0] :
                       r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
    // With a zero divisor the remainder path restores |a|, so the sign fix gives back a.
    assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    // Result selection; reserved ops yield zero.
    always_comb begin
        o_result = '0;
        case (r_op)
            OP_MUL:          o_result = w_acc_nxt[WIDTH-1:0];
            OP_MULHU:        o_result = w_acc_nxt[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: o_result = w_quo_fix;
            OP_REM, OP_REMU: o_result = w_rem_fix;
            default:         o_result = '0;
        endcase
    end

    // Operand load on accept, otherwise advance one step while busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_rem   <= '0;
            r_mcand <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
        end else if (i_load) begin
            r_op    <= i_op;
            r_rem   <= '0;
            r_neg_q <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= w_signed & i_a[WIDTH-1];
            r_div0  <= i_op[2] & (i_b == '0);
            if (i_op[2]) begin
                r_acc   <= {{WIDTH{1'b0}}, w_a_abs};
                r_mcand <= w_b_abs;
            end else begin
                r_acc   <= {{WIDTH{1'b0}}, i_b};
                r_mcand <= i_a;
            end
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
            r_rem <= w_rem_nxt;
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// Execute-stage multiply/divide sequencer: accepts one op, stalls the pipe for
// WIDTH cycles, then presents a one-cycle registered writeback.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    execute_muldiv_if.slave  bus
);
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_regdest;
    logic             r_writereg;
    logic             r_out_stall;
    logic [4:0]       r_out_regdest;
    logic             r_out_writereg;
    logic [WIDTH-1:0] r_out_wbvalue;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_result;

    assign w_accept = (r_state == ST_IDLE) && bus.in_start && !bus.in_stall && !bus.in_flush;
    assign w_step   = (r_state == ST_BUSY) && !bus.in_flush;
    assign w_last   = (r_state == ST_BUSY) && (r_cnt == CNT_W'(WIDTH - 1));

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_op     (bus.in_op),
        .i_a      (bus.in_a),
        .i_b      (bus.in_b),
        .o_result (w_result)
    );

    // Sequencer, iteration counter and registered pipeline-facing outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_regdest      <= '0;
            r_writereg     <= 1'b0;
            r_out_stall    <= 1'b0;
            r_out_regdest  <= '0;
            r_out_writereg <= 1'b0;
            r_out_wbvalue  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_out_regdest  <= '0;
                    r_out_writereg <= 1'b0;
                    r_out_wbvalue  <= '0;
                    r_out_stall    <= 1'b0;
                    if (w_accept) begin
                        r_state     <= ST_BUSY;
                        r_cnt       <= '0;
                        r_regdest   <= bus.in_regdest;
                        r_writereg  <= bus.in_writereg;
                        r_out_stall <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (bus.in_flush) begin
                        // Flush beats the final iteration: nothing is written back.
                        r_state        <= ST_IDLE;
                        r_cnt          <= '0;
                        r_out_stall    <= 1'b0;
                        r_out_writereg <= 1'b0;
                        r_out_wbvalue  <= '0;
                        r_out_regdest  <= '0;
                    end else if (w_last) begin
                        r_state        <= ST_IDLE;
                        r_cnt          <= '0;
                        r_out_stall    <= 1'b0;
                        r_out_wbvalue  <= w_result;
                        r_out_regdest  <= r_regdest;
                        r_out_writereg <= r_writereg;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_stall    = r_out_stall;
    assign bus.out_regdest  = r_out_regdest;
    assign bus.out_writereg = r_out_writereg;
    assign bus.out_wbvalue  = r_out_wbvalue;

endmodule
